// File: rtl/lif_scheduler.sv
// ============================================================================
//  Module      : lif_scheduler
//  Description : Time-multiplexed leaky-integrate-and-fire scheduler sharing
//                one update datapath across N_NEURONS neurons.
//                Optional macro LIF_SCHED_RESET_ON_SPIKE_EN: zero a neuron's
//                state after it fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic [WIDTH-1:0]     threshold,
    output logic                 cur_req,
    output logic [IDX_W-1:0]     cur_idx,
    input  logic                 cur_valid,
    input  logic [WIDTH-1:0]     cur_data,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WIDTH-1:0]     rd_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   c_NUM  = (IDX_W + 1)'(N_NEURONS);

    logic [1:0]           r_fsm;
    logic [1:0]           w_fsm_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [WIDTH-1:0]     r_thr;
    logic [WIDTH-1:0]     r_cur;
    logic [WIDTH-1:0]     r_state [N_NEURONS];
    logic [N_NEURONS-1:0] r_spike_vec;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_next;
    logic                 w_spike;
    logic                 w_last;

    // Leak is a right shift by one; the extra sum bit flags saturation.
    assign w_sum   = {1'b0, r_cur} + {2'b00, r_state[r_idx][WIDTH-1:1]};
    assign w_next  = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_spike = (w_next >= r_thr);
    assign w_last  = (r_idx == c_LAST);

    assign cur_idx   = r_idx;
    assign spike_vec = r_spike_vec;
    assign rd_state  = ({1'b0, rd_idx} < c_NUM) ? r_state[rd_idx] : {WIDTH{1'b0}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        busy      = 1'b1;
        done      = 1'b0;
        cur_req   = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                busy = 1'b0;
                if (step) begin
                    w_fsm_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                cur_req = 1'b1;
                if (cur_valid) begin
                    w_fsm_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_fsm_nxt = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done      = 1'b1;
                w_fsm_nxt = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_thr       <= '0;
            r_cur       <= '0;
            r_spike_vec <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_state[i] <= '0;
            end
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (step) begin
                        r_thr       <= threshold;
                        r_spike_vec <= '0;
                        r_idx       <= '0;
                    end
                end
                S_FETCH: begin
                    if (cur_valid) begin
                        r_cur <= cur_data;
                    end
                end
                S_UPDATE: begin
                    if (w_spike) begin
                        r_spike_vec[r_idx] <= 1'b1;
                    end
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
                    r_state[r_idx] <= w_spike ? {WIDTH{1'b0}} : w_next;
`else
                    r_state[r_idx] <= w_next;
`endif
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_scheduler.sv
// ============================================================================
//  Module      : tb_lif_scheduler
//  Description : Self-checking bench for lif_scheduler (vector table, corner
//                sequences and randomized steps against a behavioural model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
    localparam bit RST_EN = 1'b1;
`else
    localparam bit RST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          step;
    logic [W-1:0]  threshold;
    logic          cur_req;
    logic [IW-1:0] cur_idx;
    logic          cur_valid;
    logic [W-1:0]  cur_data;
    logic          busy;
    logic          done;
    logic [N-1:0]  spike_vec;
    logic [IW-1:0] rd_idx;
    logic [W-1:0]  rd_state;

    lif_scheduler #(.N_NEURONS(N), .WIDTH(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .threshold (threshold),
        .cur_req   (cur_req),
        .cur_idx   (cur_idx),
        .cur_valid (cur_valid),
        .cur_data  (cur_data),
        .busy      (busy),
        .done      (done),
        .spike_vec (spike_vec),
        .rd_idx    (rd_idx),
        .rd_state  (rd_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_state [N];

    typedef struct {
        bit                  do_rst;
        bit                  poke;
        logic [W-1:0]        thr;
        logic [N-1:0][W-1:0] cur;
        logic [N-1:0][3:0]   stl;
        logic [N-1:0][W-1:0] exp_st;
        logic [N-1:0]        exp_sp;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LIF rule: half the old state leaks away, current adds, result clips at 255.
    function automatic int lif_next(input int s, input int c);
        int n;
        n = c + s / 2;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; step = 1'b0; cur_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_state[i] = 0;
    endtask

    task automatic run_step(input logic [W-1:0] thr, input logic [N-1:0][W-1:0] cur,
                            input logic [N-1:0][3:0] stl, input bit poke);
        bit           req_a [64];
        bit           val_a [64];
        int           idx_a [64];
        int           upd_c [N];
        int           new_st [N];
        logic [N-1:0] sp;
        int           t, done_c, n;
        logic [4:0]   act, exp;
        logic [IW-1:0] ei;
        for (int i = 0; i < 64; i++) begin
            req_a[i] = 0; val_a[i] = 0; idx_a[i] = 0;
        end
        // Expected timeline: each neuron fetches (1 + stall) cycles, then updates once.
        t = 1;
        for (int j = 0; j < N; j++) begin
            for (int s = 0; s <= int'(stl[j]); s++) begin
                req_a[t + s] = 1; idx_a[t + s] = j; val_a[t + s] = (s == int'(stl[j]));
            end
            t += int'(stl[j]) + 1;
            upd_c[j] = t;
            t++;
        end
        done_c = t;
        sp = '0;
        for (int j = 0; j < N; j++) begin
            n = lif_next(m_state[j], int'(cur[j]));
            sp[j] = (n >= int'(thr));
            new_st[j] = (sp[j] && RST_EN) ? 0 : n;
        end

        @(negedge clk);
        step = 1'b1; threshold = thr; cur_valid = 1'b0;
        for (int c = 1; c <= done_c + 3; c++) begin
            @(negedge clk);
            step = poke && (c == 3 || c == 9);
            threshold = W'($urandom);
            rd_idx = IW'($urandom);
            #1;
            ei  = IW'(idx_a[c]);
            act = {busy, done, cur_req, cur_req ? cur_idx : 2'b00};
            exp = {c <= done_c, c == done_c, req_a[c], req_a[c] ? ei : 2'b00};
            chk($sformatf("ctl_c%0d", c), 32'(act), 32'(exp));
            chk($sformatf("rd_mid_c%0d_n%0d", c, rd_idx), 32'(rd_state),
                32'((c > upd_c[rd_idx]) ? new_st[rd_idx] : m_state[rd_idx]));
            if (req_a[c]) begin
                cur_valid = val_a[c];
                cur_data  = val_a[c] ? cur[idx_a[c]] : W'($urandom);
            end else begin
                cur_valid = 1'($urandom);
                cur_data  = W'($urandom);
            end
        end
        step = 1'b0; cur_valid = 1'b0;
        for (int j = 0; j < N; j++) m_state[j] = new_st[j];
        chk("spike_vec", 32'(spike_vec), 32'(sp));
        for (int r = 0; r < N; r++) begin
            rd_idx = IW'(r);
            #1;
            chk($sformatf("state_n%0d", r), 32'(rd_state), 32'(m_state[r]));
        end
    endtask

    initial begin
        logic [N-1:0][W-1:0] c120, c255, cmix, rcur;
        logic [N-1:0][3:0]   nost, st1, rstl;
        c120 = {4{8'd120}};
        c255 = {4{8'd255}};
        cmix = {8'd255, 8'd100, 8'd50, 8'd0};
        nost = '0;
        st1  = {4'd0, 4'd0, 4'd3, 4'd0};
        tbl[0] = '{1'b1, 1'b0, 8'd200, c120, nost, c120, 4'b0000};
        tbl[1] = '{1'b0, 1'b0, 8'd200, c120, nost, {4{8'd180}}, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 8'd200, c120, nost, RST_EN ? {4{8'd0}} : {4{8'd210}}, 4'b1111};
        tbl[3] = '{1'b1, 1'b0, 8'd200, c255, nost, RST_EN ? {4{8'd0}} : c255, 4'b1111};
        tbl[4] = '{1'b0, 1'b0, 8'd200, c255, nost, RST_EN ? {4{8'd0}} : c255, 4'b1111};
        tbl[5] = '{1'b0, 1'b0, 8'd200, c255, nost, RST_EN ? {4{8'd0}} : c255, 4'b1111};
        tbl[6] = '{1'b1, 1'b0, 8'd100, cmix, nost,
                   RST_EN ? {8'd0, 8'd0, 8'd50, 8'd0} : cmix, 4'b1100};
        tbl[7] = '{1'b1, 1'b0, 8'd200, c120, st1, c120, 4'b0000};
        tbl[8] = '{1'b1, 1'b1, 8'd200, c120, nost, c120, 4'b0000};

        reset = 1'b1; step = 1'b0; threshold = '0; cur_valid = 1'b0;
        cur_data = '0; rd_idx = '0;
        for (int i = 0; i < N; i++) m_state[i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ctl", 32'({busy, done, cur_req, cur_idx}), 32'd0);
        chk("rst_spike", 32'(spike_vec), 32'd0);
        for (int r = 0; r < N; r++) begin
            rd_idx = IW'(r);
            #1;
            chk($sformatf("rst_state_n%0d", r), 32'(rd_state), 32'd0);
        end

        for (int v = 0; v < 9; v++) begin
            if (tbl[v].do_rst) apply_reset();
            run_step(tbl[v].thr, tbl[v].cur, tbl[v].stl, tbl[v].poke);
            chk($sformatf("tbl%0d_spike", v), 32'(spike_vec), 32'(tbl[v].exp_sp));
            for (int r = 0; r < N; r++) begin
                rd_idx = IW'(r);
                #1;
                chk($sformatf("tbl%0d_state_n%0d", v, r), 32'(rd_state), 32'(tbl[v].exp_st[r]));
            end
        end

        // Reset asserted for two cycles while neuron 2 is being fetched.
        run_step(8'd200, c120, nost, 1'b0);
        @(negedge clk);
        step = 1'b1; threshold = 8'd200; cur_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            step = 1'b0;
            cur_valid = (c != 5);
            cur_data = 8'd120;
        end
        #1;
        chk("midrst_fetch2", 32'({cur_req, cur_idx}), 32'({1'b1, 2'd2}));
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_idle", 32'({busy, done, cur_req}), 32'd0);
        @(negedge clk);
        reset = 1'b0; cur_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("midrst_quiet%0d", c), 32'({busy, done, cur_req}), 32'd0);
            @(negedge clk);
        end
        cur_valid = 1'b0;
        chk("midrst_spike", 32'(spike_vec), 32'd0);
        for (int r = 0; r < N; r++) begin
            rd_idx = IW'(r);
            #1;
            chk($sformatf("midrst_state_n%0d", r), 32'(rd_state), 32'd0);
            m_state[r] = 0;
        end

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0) apply_reset();
            for (int j = 0; j < N; j++) begin
                rcur[j] = W'($urandom);
                rstl[j] = 4'($urandom_range(0, 2));
            end
            run_step(W'($urandom), rcur, rstl, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath across `N_NEURONS` neurons. On each `step` it walks the neuron indices in order, fetches each neuron's input current over a request/valid handshake, and applies the LIF update to a per-neuron state register file. It then records spikes and signals completion. It sits between the external stimulus source or host and the spike consumer, and replaces per-neuron instances of the single-neuron LIF cell.

## Interface
- `N_NEURONS`, default 4: number of neurons scheduled; must be ≥2.
- `WIDTH`, default 8: membrane state, current and threshold width in bits.
- `IDX_W`, default 2: index width; must satisfy 2^IDX_W ≥ N_NEURONS.

- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `step`  input  1  start one timestep; sampled only in IDLE.
- `threshold`  input  WIDTH  spike threshold; latched when `step` is accepted.
- `cur_req`  output  1  current request for neuron `cur_idx`.
- `cur_idx`  output  IDX_W  index of the requested neuron.
- `cur_valid`  input  1  current data valid; a transfer occurs when `cur_req && cur_valid`.
- `cur_data`  input  WIDTH  input current for `cur_idx`.
- `busy`  output  1  high in every non-IDLE state.
- `done`  output  1  one-cycle pulse when the timestep completes.
- `spike_vec`  output  N_NEURONS  per-neuron spike flags for the last completed timestep.
- `rd_idx`  input  IDX_W  state readout index.
- `rd_state`  output  WIDTH  combinational read of `state[rd_idx]`; 0 if `rd_idx ≥ N_NEURONS`.

## Operation
- FSM states: IDLE, FETCH, UPDATE, DONE.
- **IDLE**
  - If `step`=1: latch `threshold`, clear `spike_vec`, set idx=0, go to FETCH.
  - Otherwise hold.
- **FETCH**
  - `cur_req`=1 and `cur_idx`=idx.
  - On `cur_valid`=1, latch `cur_data` and go to UPDATE.
  - Otherwise stay; there is no timeout.
- **UPDATE**
  - Compute sum = `cur_latched` + (`state[idx]` >> 1) at WIDTH+1 bits.
  - next = saturate to 2^WIDTH−1.
  - spike = (next ≥ latched threshold); if spike, set `spike_vec[idx]`=1.
  - Write `state[idx]` per the Configuration section.
  - If idx = N_NEURONS−1, go to DONE; else idx+1 and go to FETCH.
- **DONE**
  - `done`=1 for exactly this cycle, then go to IDLE.
- `spike_vec` holds its value from DONE until the next accepted `step`.
- `step` while `busy` is ignored; it is not queued.
- `cur_valid` outside FETCH is ignored.
- `threshold` changes mid-step have no effect.
- The readout port may be used at any time.
  - During a step, a read returns the pre-update value until that neuron's UPDATE cycle commits.

## Timing
- Reset values:
  - FSM=IDLE, `busy`=0, `done`=0, `cur_req`=0, `cur_idx`=0, `spike_vec`=0.
  - All `state[i]`=0, latched threshold=0.
- Reset mid-step aborts immediately: next cycle is IDLE, no `done` pulse, partially updated states are cleared to 0.
- `step` is accepted at cycle 0.
- Neuron k FETCH begins at cycle 1+2k+S_k, where S_k is the cumulative number of stall cycles in which `cur_valid`=0 before neuron k.
- With zero stall, `done` is high in cycle 2·N_NEURONS+1 and IDLE resumes at cycle 2·N_NEURONS+2.
  - N_NEURONS=4: `done` at cycle 9.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `step` is accepted no earlier than the first IDLE cycle, giving back-to-back period 2·N_NEURONS+2.
- `cur_req` remains asserted continuously across stall cycles.
- `cur_idx` is stable while `cur_req` is high.

## Configuration
- Macro: `LIF_SCHED_RESET_ON_SPIKE_EN`.
- Defined: a neuron that spikes has `state[idx]` written to 0 (hard reset after firing); non-spiking neurons store next.
- Undefined: `state[idx]` = next always, and a neuron above threshold keeps spiking every step.

## Test plan
- **Reset:** assert `reset` 2 cycles mid-FETCH at neuron 2. Required: IDLE next cycle, `busy`=0, no `done`, all `rd_state`=0, `spike_vec`=0.
- **Integration to spike:** N=4, `threshold`=200, `cur_data`=120 for all neurons, `cur_valid` tied high, three steps. Required:
  - States 120, 180, then 210.
  - `spike_vec`=0000, 0000, then 1111.
  - `done` at cycle 9 of each step.
  - Macro defined: `rd_state`=0 after step 3.
- **Saturation:** preload to 255 via repeated `cur_data`=255, then one more step with `cur_data`=255. Required: `state`=255 (not 126), `spike_vec`=1111 for `threshold`=200.
- **Handshake stall:** `cur_valid` held low 3 cycles for neuron 1 only. Required: `cur_req` high and `cur_idx`=1 throughout the stall, `done` at cycle 12, states identical to the no-stall run.
- **Ignored step:** pulse `step` at cycles 3 and 9 of a running step. Required: exactly one `done`, no second timestep starts, latched `threshold` unchanged.
- **Mixed currents:** `threshold`=100, currents {0,50,100,255}, one step from reset. Required: `spike_vec`=1100 (neuron3 and neuron2 set, bit i = neuron i), `rd_state` {0,50,100,255} with macro undefined.
